// File: rtl/mult_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arb
// Brief    : Shares one start/ready multiplier among NREQ requesters.
//            Optional macro MULT_SHARE_ARB_ROUND_ROBIN_EN enables a rotating
//            priority pointer; otherwise the lowest requesting index wins.
// Revision : 1.0
// ============================================================================
module mult_share_arb #(
  parameter int NREQ     = 4,
  parameter int DP_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*DP_WIDTH-1:0]   a_in,
  input  logic [NREQ*DP_WIDTH-1:0]   b_in,
  output logic [NREQ-1:0]            ack,
  output logic [2*DP_WIDTH-1:0]      result,
  output logic                       busy,
  output logic                       m_start,
  output logic [DP_WIDTH-1:0]        m_multiplicand,
  output logic [DP_WIDTH-1:0]        m_multiplier,
  input  logic                       m_rdy,
  input  logic [2*DP_WIDTH-1:0]      m_product
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [IDX_W-1:0]     grant;
  logic [IDX_W-1:0]     win;
  logic [IDX_W-1:0]     idx;
  logic                 found;
  logic [DP_WIDTH-1:0]  sel_a;
  logic [DP_WIDTH-1:0]  sel_b;

`ifdef MULT_SHARE_ARB_ROUND_ROBIN_EN
  localparam logic [IDX_W:0]   NREQ_CNT = (IDX_W+1)'(NREQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ-1);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   sum;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ptr <= '0;
    end else if (state == RESP) begin
      ptr <= (grant == LAST_IDX) ? '0 : grant + IDX_W'(1);
    end
  end
`endif

  // Scan candidates in priority order; the first requesting one wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
`ifdef MULT_SHARE_ARB_ROUND_ROBIN_EN
    sum   = '0;
`endif
    for (int k = 0; k < NREQ; k++) begin
`ifdef MULT_SHARE_ARB_ROUND_ROBIN_EN
      sum = {1'b0, ptr} + k[IDX_W:0];
      if (sum >= NREQ_CNT) begin
        sum = sum - NREQ_CNT;
      end
      idx = sum[IDX_W-1:0];
`else
      idx = k[IDX_W-1:0];
`endif
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == k[IDX_W-1:0]) begin
        sel_a = a_in[k*DP_WIDTH +: DP_WIDTH];
        sel_b = b_in[k*DP_WIDTH +: DP_WIDTH];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found && m_rdy) state_nx = ISSUE;
      ISSUE:   if (!m_rdy)         state_nx = WAIT;
      WAIT:    if (m_rdy)          state_nx = RESP;
      RESP:                        state_nx = IDLE;
      default:                     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state          <= IDLE;
      grant          <= '0;
      m_multiplicand <= '0;
      m_multiplier   <= '0;
      result         <= '0;
    end else begin
      state <= state_nx;
      // Operands are frozen here and held until the next grant.
      if (state == IDLE && state_nx == ISSUE) begin
        grant          <= win;
        m_multiplicand <= sel_a;
        m_multiplier   <= sel_b;
      end
      if (state == WAIT && m_rdy) begin
        result <= m_product;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign m_start = (state == ISSUE);

  always_comb begin
    ack = '0;
    if (state == RESP) begin
      ack[grant] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arb.sv
`default_nettype none
// Bench for mult_share_arb: random and directed requesters, a start/ready
// multiplier model, and a scoreboard checked by an independent monitor.
module tb_mult_share_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  typedef struct {
    int              idx;
    logic [2*DW-1:0] prod;
  } exp_t;

  logic              clk   = 1'b0;
  logic              rst_b = 1'b0;
  logic [N-1:0]      req   = '0;
  logic [N*DW-1:0]   a_in  = '0;
  logic [N*DW-1:0]   b_in  = '0;
  logic [N-1:0]      ack;
  logic [2*DW-1:0]   result;
  logic              busy;
  logic              m_start;
  logic [DW-1:0]     m_multiplicand;
  logic [DW-1:0]     m_multiplier;
  logic              m_rdy;
  logic [2*DW-1:0]   m_product = '0;

  int checks   = 0;
  int failures = 0;

  exp_t exp_q[$];
  int   ack_log[$];
  int   remaining[N];

  always #5 clk = ~clk;

  mult_share_arb #(.NREQ(N), .DP_WIDTH(DW)) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .req            (req),
    .a_in           (a_in),
    .b_in           (b_in),
    .ack            (ack),
    .result         (result),
    .busy           (busy),
    .m_start        (m_start),
    .m_multiplicand (m_multiplicand),
    .m_multiplier   (m_multiplier),
    .m_rdy          (m_rdy),
    .m_product      (m_product)
  );

  // Multiplier model: takes a start while ready, stays busy 1..4 cycles.
  logic            mul_idle = 1'b1;
  logic            mul_hold = 1'b0;
  int              mul_cnt  = 0;
  logic [2*DW-1:0] mul_a    = '0;
  logic [2*DW-1:0] mul_b    = '0;

  assign m_rdy = mul_idle & ~mul_hold;

  always @(posedge clk) begin
    if (mul_idle) begin
      if (m_start && m_rdy) begin
        mul_a     <= {{DW{1'b0}}, m_multiplicand};
        mul_b     <= {{DW{1'b0}}, m_multiplier};
        mul_idle  <= 1'b0;
        mul_cnt   <= int'($urandom_range(0, 3));
        m_product <= (2*DW)'($urandom);
      end
    end else if (mul_cnt == 0) begin
      mul_idle  <= 1'b1;
      m_product <= mul_a * mul_b;
    end else begin
      mul_cnt <= mul_cnt - 1;
    end
  end

  function automatic int pick(input logic [N-1:0] r, input int p);
    int i;
    for (int k = 0; k < N; k++) begin
`ifdef MULT_SHARE_ARB_ROUND_ROBIN_EN
      i = (p + k) % N;
`else
      i = k;
`endif
      if (r[i[IW-1:0]]) return i;
    end
    return -1;
  endfunction

  // Monitor: arbitration order, latency, one-hot ack, result vs scoreboard.
  int              rr_ptr      = 0;
  int              exp_win     = -1;
  logic            prev_busy   = 1'b0;
  logic            prev_mstart = 1'b0;
  logic            prev_mrdy   = 1'b0;
  logic [N-1:0]    prev_req    = '0;
  logic [N-1:0]    prev_ack    = '0;
  logic [2*DW-1:0] held_result = '0;

  always @(negedge clk) begin
    int idx;
    int pos;
    if (!rst_b) begin
      rr_ptr      = 0;
      exp_win     = -1;
      held_result = '0;
      prev_busy   = 1'b0;
      prev_mstart = 1'b0;
      prev_mrdy   = 1'b0;
      prev_ack    = '0;
    end else begin
      checks++;
      if (m_start && !busy) begin
        failures++;
        $display("FAIL start_outside_issue m_start=%b busy=%b required m_start=0", m_start, busy);
      end
      if (ack != '0) begin
        idx = -1;
        for (int k = 0; k < N; k++) if (ack[k[IW-1:0]]) idx = k;
        checks++;
        if (!$onehot(ack)) begin
          failures++;
          $display("FAIL ack_onehot ack=%b required one-hot", ack);
        end
        checks++;
        if (idx != exp_win) begin
          failures++;
          $display("FAIL arbitration acked=%0d required=%0d", idx, exp_win);
        end
        checks++;
        if (!(prev_busy && prev_mrdy && !prev_mstart && prev_ack == '0)) begin
          failures++;
          $display("FAIL ack_latency prev busy=%b m_rdy=%b m_start=%b required ack one cycle after m_rdy high in WAIT",
                   prev_busy, prev_mrdy, prev_mstart);
        end
        pos = -1;
        for (int j = 0; j < exp_q.size(); j++) if (pos < 0 && exp_q[j].idx == idx) pos = j;
        checks++;
        if (pos < 0) begin
          failures++;
          $display("FAIL unexpected_ack ack=%b with no outstanding request", ack);
        end else begin
          if (result !== exp_q[pos].prod) begin
            failures++;
            $display("FAIL result req=%0d got=%h required=%h", idx, result, exp_q[pos].prod);
          end
          exp_q.delete(pos);
        end
        held_result = result;
        ack_log.push_back(idx);
        rr_ptr = (idx + 1) % N;
      end else begin
        checks++;
        if (result !== held_result) begin
          failures++;
          $display("FAIL result_hold got=%h required=%h", result, held_result);
        end
      end
      if (busy && !prev_busy) exp_win = pick(prev_req, rr_ptr);
      prev_busy   = busy;
      prev_mstart = m_start;
      prev_mrdy   = m_rdy;
      prev_ack    = ack;
    end
    prev_req = req;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  task automatic issue(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    a_in[i*DW +: DW] = a;
    b_in[i*DW +: DW] = b;
    req[i[IW-1:0]]   = 1'b1;
    e.idx  = i;
    e.prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    exp_q.push_back(e);
  endtask

  // One clock; requesters acked this cycle drop req or chain a new job.
  task automatic step();
    logic [N-1:0] seen;
    logic [DW-1:0] ra, rb;
    @(negedge clk);
    seen = ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (seen[i[IW-1:0]]) begin
        if (remaining[i] > 0) begin
          remaining[i]--;
          ra = DW'($urandom);
          rb = DW'($urandom);
          issue(i, ra, rb);
        end else begin
          req[i[IW-1:0]] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    step();
    while ((req != '0 || busy || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s req=%b busy=%b pending=%0d required idle", name, req, busy, exp_q.size());
    end
  endtask

  task automatic wait_in_wait(input int budget, input string name);
    int n;
    n = 0;
    while (!(busy && !m_start && ack == '0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s busy=%b m_start=%b required WAIT", name, busy, m_start);
    end
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    req   = '0;
    exp_q.delete();
    for (int i = 0; i < N; i++) remaining[i] = 0;
    step();
    step();
    rst_b = 1'b1;
    step();
  endtask

  initial begin
    int exp_order[5];
    logic [DW-1:0] ra, rb;
    bit started[N];

    for (int i = 0; i < N; i++) remaining[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack",     32'(ack), 32'h0);
    check("reset_busy",    32'(busy), 32'h0);
    check("reset_m_start", 32'(m_start), 32'h0);
    check("reset_result",  32'(result), 32'h0);
    check("reset_mcand",   32'(m_multiplicand), 32'h0);
    check("reset_mplier",  32'(m_multiplier), 32'h0);
    rst_b = 1'b1;
    step();

    issue(1, 8'd12, 8'd13);
    wait_idle(50, "single");
    check("single_result", 32'(result), 32'd156);
    check("single_acker",  32'(ack_log[ack_log.size()-1]), 32'd1);

    issue(0, 8'd255, 8'd255);
    wait_idle(50, "max");
    check("max_result", 32'(result), 32'hFE01);

    issue(3, 8'd100, 8'd7);
    wait_in_wait(20, "opchg");
    a_in[3*DW +: DW] = 8'd1;
    b_in[3*DW +: DW] = 8'd2;
    check("opchg_mcand",  32'(m_multiplicand), 32'd100);
    check("opchg_mplier", 32'(m_multiplier), 32'd7);
    wait_idle(50, "opchg");
    check("opchg_result", 32'(result), 32'd700);

    issue(2, 8'd9, 8'd9);
    wait_in_wait(20, "rstwait");
    mul_hold = 1'b1;
    rst_b    = 1'b0;
    #1;
    check("rst_busy",    32'(busy), 32'h0);
    check("rst_ack",     32'(ack), 32'h0);
    check("rst_m_start", 32'(m_start), 32'h0);
    check("rst_result",  32'(result), 32'h0);
    req = '0;
    exp_q.delete();
    step();
    step();
    rst_b = 1'b1;
    issue(0, 8'd3, 8'd5);
    for (int c = 0; c < 6; c++) begin
      step();
      check("hold_m_start", 32'(m_start), 32'h0);
      check("hold_busy",    32'(busy), 32'h0);
    end
    mul_hold = 1'b0;
    wait_idle(50, "after_rst");
    check("after_rst_result", 32'(result), 32'd15);

    do_reset();
`ifdef MULT_SHARE_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    ack_log.delete();
    for (int i = 0; i < N; i++) begin
      remaining[i] = 4;
      ra = DW'($urandom);
      rb = DW'($urandom);
      issue(i, ra, rb);
    end
    wait_idle(800, "contention");
    check("contention_count", 32'(ack_log.size()), 32'd20);
    for (int k = 0; k < 5; k++) begin
      if (k < ack_log.size()) check("contention_order", 32'(ack_log[k]), 32'(exp_order[k]));
    end

    for (int i = 0; i < N; i++) started[i] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!started[i] && $urandom_range(0, 3) == 0) begin
          started[i]   = 1'b1;
          remaining[i] = int'($urandom_range(2, 6));
          ra = DW'($urandom);
          rb = DW'($urandom);
          issue(i, ra, rb);
        end
      end
      step();
    end
    wait_idle(2000, "random");

    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        issue(2, DW'(a), DW'(b));
        wait_idle(40, "sweep");
      end
    end
    check("sweep_last", 32'(result), 32'd961);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_share_arb.md
MULT_SHARE_ARB -- requirements
Module: mult_share_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one multiplier (2..8).
REQ-002 SHALL have parameter DP_WIDTH, default 8, operand width; product width is 2*DP_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  NREQ  per-requester level request, held until that requester's ack.
REQ-006 SHALL have port a_in  input  NREQ*DP_WIDTH  packed multiplicands; slice i belongs to requester i.
REQ-007 SHALL have port b_in  input  NREQ*DP_WIDTH  packed multipliers; slice i belongs to requester i.
REQ-008 SHALL have port ack  output  NREQ  one-hot, one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port result  output  2*DP_WIDTH  product for the requester acked; held until the next ack.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 SHALL have port m_start  output  1  start strobe to the multiplier.
REQ-012 SHALL have port m_multiplicand  output  DP_WIDTH  latched operand A to the multiplier.
REQ-013 SHALL have port m_multiplier  output  DP_WIDTH  latched operand B to the multiplier.
REQ-014 SHALL have port m_rdy  input  1  multiplier ready/done; low while multiplying.
REQ-015 SHALL have port m_product  input  2*DP_WIDTH  multiplier product, valid while m_rdy is high.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: when any req bit is high and m_rdy=1, SHALL select one winner, latch its a_in/b_in slices into m_multiplicand/m_multiplier, register the grant index, and go to ISSUE; with m_rdy=0, SHALL stay in IDLE.
REQ-018 ISSUE: SHALL drive m_start=1; on sampling m_rdy=0, SHALL go to WAIT; otherwise SHALL stay in ISSUE with m_start held.
REQ-019 WAIT: SHALL drive m_start=0; on sampling m_rdy=1, SHALL capture m_product into result and go to RESP.
REQ-020 RESP: SHALL drive ack[grant]=1 for exactly one cycle, then go to IDLE; result valid in the same cycle as ack.
REQ-021 Requester SHALL drop req on the edge that samples its ack; the arbiter SHALL sample req only in IDLE.
REQ-022 Latched operands SHALL stay constant from ISSUE through RESP regardless of a_in/b_in changes.
REQ-023 Latency: ack SHALL assert exactly one cycle after m_rdy is sampled high in WAIT; minimum req-to-ack is 4 cycles plus multiplier time.
REQ-024 Requests asserted while busy SHALL be held pending and considered at the next IDLE; none SHALL be lost.
REQ-025 ack SHALL never have more than one bit set; m_start SHALL be 0 outside ISSUE.
REQ-026 result SHALL be the full 2*DP_WIDTH product (e.g. DP_WIDTH=8: 255*255 = 16'hFE01), with no truncation.

Reset
REQ-027 On rst_b=0, SHALL enter IDLE immediately: ack=0, busy=0, m_start=0, result=0, m_multiplicand=0, m_multiplier=0, grant index=0, priority pointer=0.
REQ-028 Reset mid-operation SHALL abandon the transaction with no ack; after release, SHALL wait in IDLE for m_rdy=1 before any new issue.

Configuration
REQ-029 With macro MULT_SHARE_ARB_ROUND_ROBIN_EN defined, SHALL select the first requesting index at or above a rotating pointer, wrapping NREQ-1 to 0; in RESP the pointer SHALL become grant+1 mod NREQ.
REQ-030 Without MULT_SHARE_ARB_ROUND_ROBIN_EN, SHALL use fixed priority: lowest requesting index wins; no pointer state.

Verification
REQ-031 Single: req=4'b0010, a1=12, b1=13 -> m_start pulse, ack=4'b0010 one cycle after m_rdy rises, result=156.
REQ-032 Max: req0, a0=255, b0=255 -> result=16'hFE01.
REQ-033 Contention (RR): req=4'b1111 held, re-raised after each ack -> ack order 0,1,2,3,0; without macro -> ack0 repeatedly.
REQ-034 Operand change: change a_in slice during WAIT -> result reflects the value latched in IDLE.
REQ-035 Reset in WAIT: rst_b=0 -> ack never asserts, busy=0 same cycle; hold m_rdy=0 after release -> m_start stays 0.
REQ-036 Exhaustive: sweep 0..31 x 0..31 through requester 2 -> every result equals a*b; ack is always one-hot.
